// File: rtl/axil_csr_timeout_guard_if.sv
// ---------------------------------------------------------------------------
// axil_csr_timeout_guard_if
// AXI-lite bus bundle used on both sides of the CSR timeout guard.
//   master modport : drives AW/W/AR channels and the B/R ready signals
//   slave  modport : drives AW/W/AR ready signals and the B/R channels
// Parameters ADDR_W / DATA_W set the address and data widths; the strobe is
// DATA_W/8 bits wide.
// ---------------------------------------------------------------------------
interface axil_csr_timeout_guard_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_csr_timeout_guard.sv
// ---------------------------------------------------------------------------
// axil_csr_timeout_guard
// Pass-through AXI-lite guard between the host MMIO bridge and the CSR
// fabric. Every upstream transaction gets a completion: if the fabric does
// not answer within TIMEOUT_CYCLES a SLVERR response is returned upstream,
// the late downstream response is later absorbed, and debug statistics are
// captured.
// Ports:
//   clk, rst       : single clock, synchronous active-high reset
//   s_if           : upstream slave side (from the bridge)
//   m_if           : downstream master side (to the CSR fabric)
//   clr_stat       : pulse clearing the flags, counter and captured address
//   o_wr_timeout   : sticky, some write has timed out
//   o_rd_timeout   : sticky, some read has timed out
//   o_timeout_cnt  : saturating count of all timeouts
//   o_err_addr     : address of the most recent timed-out transaction
// TIMEOUT_CYCLES must lie in 2..65535.
// ---------------------------------------------------------------------------
module axil_csr_timeout_guard #(
    parameter int ADDR_W         = 19,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    axil_csr_timeout_guard_if.slave  s_if,
    axil_csr_timeout_guard_if.master m_if,
    input  logic                   clr_stat,
    output logic                   o_wr_timeout,
    output logic                   o_rd_timeout,
    output logic [CNT_W-1:0]       o_timeout_cnt,
    output logic [ADDR_W-1:0]      o_err_addr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int TO_W   = 16;
    localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;

    // ---------------- write path state ----------------
    w_state_e            w_state_q;
    logic                s_awready_q, s_wready_q;
    logic                aw_got_q, w_got_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [2:0]          awprot_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    // Downstream payload is held separately so a fail-fast capture can never
    // disturb a stale transaction still presented to the fabric.
    logic [ADDR_W-1:0]   m_awaddr_q;
    logic [2:0]          m_awprot_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [STRB_W-1:0]   m_wstrb_q;
    logic                m_awvalid_q, m_wvalid_q, m_bready_q;
    logic                s_bvalid_q;
    logic [1:0]          s_bresp_q;
    logic [TO_W-1:0]     wcnt_q;
    logic                wr_stale_q;

    // ---------------- read path state ----------------
    r_state_e            r_state_q;
    logic                s_arready_q;
    logic [ADDR_W-1:0]   m_araddr_q;
    logic [2:0]          m_arprot_q;
    logic                m_arvalid_q, m_rready_q;
    logic                s_rvalid_q;
    logic [DATA_W-1:0]   s_rdata_q;
    logic [1:0]          s_rresp_q;
    logic [TO_W-1:0]     rcnt_q;
    logic                rd_stale_q;

    // ---------------- status ----------------
    logic                wr_flag_q, wr_flag_d;
    logic                rd_flag_q, rd_flag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [CNT_W:0]      cnt_base_s, cnt_sum_s;
    logic [1:0]          inc_s;

    // ---------------- handshake / event decode ----------------
    logic aw_hs_s, w_hs_s, aw_have_s, w_have_s, m_b_hs_s, wr_to_s;
    logic ar_hs_s, m_r_hs_s, rd_to_s;

    assign aw_hs_s   = s_if.awvalid && s_awready_q;
    assign w_hs_s    = s_if.wvalid && s_wready_q;
    assign aw_have_s = aw_got_q || aw_hs_s;
    assign w_have_s  = w_got_q || w_hs_s;
    assign m_b_hs_s  = m_if.bvalid && m_bready_q;
    // A response in the limit cycle wins over the timeout.
    assign wr_to_s   = ((w_state_q == W_ISSUE) || (w_state_q == W_WAIT)) &&
                       (wcnt_q == TO_LIMIT) && !m_b_hs_s;

    assign ar_hs_s   = s_if.arvalid && s_arready_q;
    assign m_r_hs_s  = m_if.rvalid && m_rready_q;
    assign rd_to_s   = ((r_state_q == R_ISSUE) || (r_state_q == R_WAIT)) &&
                       (rcnt_q == TO_LIMIT) && !m_r_hs_s;

    // ---------------- output wiring ----------------
    assign s_if.awready  = s_awready_q;
    assign s_if.wready   = s_wready_q;
    assign s_if.bvalid   = s_bvalid_q;
    assign s_if.bresp    = s_bresp_q;
    assign s_if.arready  = s_arready_q;
    assign s_if.rvalid   = s_rvalid_q;
    assign s_if.rdata    = s_rdata_q;
    assign s_if.rresp    = s_rresp_q;

    assign m_if.awaddr   = m_awaddr_q;
    assign m_if.awprot   = m_awprot_q;
    assign m_if.awvalid  = m_awvalid_q;
    assign m_if.wdata    = m_wdata_q;
    assign m_if.wstrb    = m_wstrb_q;
    assign m_if.wvalid   = m_wvalid_q;
    assign m_if.bready   = m_bready_q;
    assign m_if.araddr   = m_araddr_q;
    assign m_if.arprot   = m_arprot_q;
    assign m_if.arvalid  = m_arvalid_q;
    assign m_if.rready   = m_rready_q;

    assign o_wr_timeout  = wr_flag_q;
    assign o_rd_timeout  = rd_flag_q;
    assign o_timeout_cnt = cnt_q;
    assign o_err_addr    = err_addr_q;

    // Write FSM: capture AW/W, issue downstream, time out, absorb late B.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awaddr_q    <= {ADDR_W{1'b0}};
            awprot_q    <= 3'b000;
            wdata_q     <= {DATA_W{1'b0}};
            wstrb_q     <= {STRB_W{1'b0}};
            m_awaddr_q  <= {ADDR_W{1'b0}};
            m_awprot_q  <= 3'b000;
            m_wdata_q   <= {DATA_W{1'b0}};
            m_wstrb_q   <= {STRB_W{1'b0}};
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= 2'b00;
            wcnt_q      <= {TO_W{1'b0}};
            wr_stale_q  <= 1'b0;
        end else begin
            // Downstream valids drop only on acceptance, in any state.
            if (m_awvalid_q && m_if.awready) begin
                m_awvalid_q <= 1'b0;
            end
            if (m_wvalid_q && m_if.wready) begin
                m_wvalid_q <= 1'b0;
            end
            // Late B of a timed-out write is swallowed here.
            if (wr_stale_q && m_b_hs_s) begin
                wr_stale_q <= 1'b0;
                m_bready_q <= 1'b0;
            end
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awaddr_q <= s_if.awaddr;
                        awprot_q <= s_if.awprot;
                    end
                    if (w_hs_s) begin
                        wdata_q <= s_if.wdata;
                        wstrb_q <= s_if.wstrb;
                    end
                    if (aw_have_s && w_have_s) begin
                        aw_got_q    <= 1'b0;
                        w_got_q     <= 1'b0;
                        s_awready_q <= 1'b0;
                        s_wready_q  <= 1'b0;
                        if (wr_stale_q) begin
                            w_state_q  <= W_RESP;
                            s_bvalid_q <= 1'b1;
                            s_bresp_q  <= RESP_SLVERR;
                        end else begin
                            w_state_q   <= W_ISSUE;
                            m_awaddr_q  <= aw_got_q ? awaddr_q : s_if.awaddr;
                            m_awprot_q  <= aw_got_q ? awprot_q : s_if.awprot;
                            m_wdata_q   <= w_got_q ? wdata_q : s_if.wdata;
                            m_wstrb_q   <= w_got_q ? wstrb_q : s_if.wstrb;
                            m_awvalid_q <= 1'b1;
                            m_wvalid_q  <= 1'b1;
                            wcnt_q      <= {TO_W{1'b0}};
                        end
                    end else begin
                        aw_got_q    <= aw_have_s;
                        w_got_q     <= w_have_s;
                        s_awready_q <= !aw_have_s;
                        s_wready_q  <= !w_have_s;
                    end
                end
                W_ISSUE: begin
                    wcnt_q <= wcnt_q + 16'd1;
                    if (wr_to_s) begin
                        // The B is necessarily still outstanding, so the path goes stale.
                        w_state_q  <= W_RESP;
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= RESP_SLVERR;
                        m_bready_q <= 1'b1;
                        wr_stale_q <= 1'b1;
                    end else if ((!m_awvalid_q || m_if.awready) &&
                                 (!m_wvalid_q || m_if.wready)) begin
                        w_state_q  <= W_WAIT;
                        m_bready_q <= 1'b1;
                    end else begin
                        w_state_q <= W_ISSUE;
                    end
                end
                W_WAIT: begin
                    wcnt_q <= wcnt_q + 16'd1;
                    if (m_b_hs_s) begin
                        w_state_q  <= W_RESP;
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= m_if.bresp;
                        m_bready_q <= 1'b0;
                    end else if (wr_to_s) begin
                        w_state_q  <= W_RESP;
                        s_bvalid_q <= 1'b1;
                        s_bresp_q  <= RESP_SLVERR;
                        wr_stale_q <= 1'b1;
                    end else begin
                        w_state_q <= W_WAIT;
                    end
                end
                W_RESP: begin
                    if (s_if.bready) begin
                        s_bvalid_q  <= 1'b0;
                        s_awready_q <= 1'b1;
                        s_wready_q  <= 1'b1;
                        w_state_q   <= W_IDLE;
                    end else begin
                        w_state_q <= W_RESP;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: capture AR, issue downstream, time out, absorb late R.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            s_arready_q <= 1'b0;
            m_araddr_q  <= {ADDR_W{1'b0}};
            m_arprot_q  <= 3'b000;
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_rdata_q   <= {DATA_W{1'b0}};
            s_rresp_q   <= 2'b00;
            rcnt_q      <= {TO_W{1'b0}};
            rd_stale_q  <= 1'b0;
        end else begin
            if (m_arvalid_q && m_if.arready) begin
                m_arvalid_q <= 1'b0;
            end
            // Late R of a timed-out read is swallowed here.
            if (rd_stale_q && m_r_hs_s) begin
                rd_stale_q <= 1'b0;
                m_rready_q <= 1'b0;
            end
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        s_arready_q <= 1'b0;
                        if (rd_stale_q) begin
                            r_state_q  <= R_RESP;
                            s_rvalid_q <= 1'b1;
                            s_rdata_q  <= {DATA_W{1'b1}};
                            s_rresp_q  <= RESP_SLVERR;
                        end else begin
                            r_state_q   <= R_ISSUE;
                            m_araddr_q  <= s_if.araddr;
                            m_arprot_q  <= s_if.arprot;
                            m_arvalid_q <= 1'b1;
                            rcnt_q      <= {TO_W{1'b0}};
                        end
                    end else begin
                        s_arready_q <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    rcnt_q <= rcnt_q + 16'd1;
                    if (rd_to_s) begin
                        r_state_q  <= R_RESP;
                        s_rvalid_q <= 1'b1;
                        s_rdata_q  <= {DATA_W{1'b1}};
                        s_rresp_q  <= RESP_SLVERR;
                        m_rready_q <= 1'b1;
                        rd_stale_q <= 1'b1;
                    end else if (!m_arvalid_q || m_if.arready) begin
                        r_state_q  <= R_WAIT;
                        m_rready_q <= 1'b1;
                    end else begin
                        r_state_q <= R_ISSUE;
                    end
                end
                R_WAIT: begin
                    rcnt_q <= rcnt_q + 16'd1;
                    if (m_r_hs_s) begin
                        r_state_q  <= R_RESP;
                        s_rvalid_q <= 1'b1;
                        s_rdata_q  <= m_if.rdata;
                        s_rresp_q  <= m_if.rresp;
                        m_rready_q <= 1'b0;
                    end else if (rd_to_s) begin
                        r_state_q  <= R_RESP;
                        s_rvalid_q <= 1'b1;
                        s_rdata_q  <= {DATA_W{1'b1}};
                        s_rresp_q  <= RESP_SLVERR;
                        rd_stale_q <= 1'b1;
                    end else begin
                        r_state_q <= R_WAIT;
                    end
                end
                R_RESP: begin
                    if (s_if.rready) begin
                        s_rvalid_q  <= 1'b0;
                        s_arready_q <= 1'b1;
                        r_state_q   <= R_IDLE;
                    end else begin
                        r_state_q <= R_RESP;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign inc_s = {1'b0, wr_to_s} + {1'b0, rd_to_s};

    // Status next-state: timeouts take priority over a coincident clear.
    always_comb begin
        cnt_base_s = {(CNT_W+1){1'b0}};
        cnt_sum_s  = {(CNT_W+1){1'b0}};
        cnt_d      = cnt_q;
        wr_flag_d  = wr_flag_q;
        rd_flag_d  = rd_flag_q;
        err_addr_d = err_addr_q;

        if (clr_stat) begin
            cnt_base_s = {(CNT_W+1){1'b0}};
        end else begin
            cnt_base_s = {1'b0, cnt_q};
        end
        cnt_sum_s = cnt_base_s + (CNT_W+1)'(inc_s);
        // Saturate instead of wrapping.
        if (cnt_sum_s[CNT_W]) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = cnt_sum_s[CNT_W-1:0];
        end

        wr_flag_d = (wr_flag_q && !clr_stat) || wr_to_s;
        rd_flag_d = (rd_flag_q && !clr_stat) || rd_to_s;

        // Read address wins when both paths time out together.
        if (rd_to_s) begin
            err_addr_d = m_araddr_q;
        end else if (wr_to_s) begin
            err_addr_d = m_awaddr_q;
        end else if (clr_stat) begin
            err_addr_d = {ADDR_W{1'b0}};
        end else begin
            err_addr_d = err_addr_q;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_flag_q  <= 1'b0;
            rd_flag_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            err_addr_q <= {ADDR_W{1'b0}};
        end else begin
            wr_flag_q  <= wr_flag_d;
            rd_flag_q  <= rd_flag_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_axil_csr_timeout_guard.sv
// ---------------------------------------------------------------------------
// tb_axil_csr_timeout_guard
// Directed bench for the CSR timeout guard. TIMEOUT_CYCLES is 16 and the
// statistics counter is 2 bits wide so that saturation is reached with a
// handful of timeouts. The bench plays both the bridge and the CSR fabric.
// ---------------------------------------------------------------------------
module tb_axil_csr_timeout_guard;
    localparam int AW = 19;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_stat;
    logic          o_wr_timeout;
    logic          o_rd_timeout;
    logic [CW-1:0] o_timeout_cnt;
    logic [AW-1:0] o_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axil_csr_timeout_guard_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();
    axil_csr_timeout_guard_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

    axil_csr_timeout_guard #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_if(s_bus),
        .m_if(m_bus),
        .clr_stat(clr_stat),
        .o_wr_timeout(o_wr_timeout),
        .o_rd_timeout(o_rd_timeout),
        .o_timeout_cnt(o_timeout_cnt),
        .o_err_addr(o_err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Read that the fabric accepts but never answers; late R after late_gap.
    task automatic rd_timeout(input logic [AW-1:0] ra, input logic clr_at_to,
                              input logic [CW-1:0] exp_cnt, input logic exp_wr,
                              input int late_gap);
        m_bus.arready = 1'b1;
        s_bus.araddr  = ra;
        s_bus.arvalid = 1'b1;
        tick();                       // enters R_ISSUE, count 0
        s_bus.arvalid = 1'b0;
        chk("rto_m_arvalid", m_bus.arvalid, 64'd1);
        chk("rto_m_araddr", m_bus.araddr, 64'(ra));
        ticks(15);
        chk("rto_early_rvalid", s_bus.rvalid, 64'd0);
        clr_stat = clr_at_to;
        tick();                       // count 15 -> timeout response
        clr_stat = 1'b0;
        chk("rto_rvalid", s_bus.rvalid, 64'd1);
        chk("rto_rdata", s_bus.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rto_rresp", s_bus.rresp, 64'd2);
        chk("rto_rd_flag", o_rd_timeout, 64'd1);
        chk("rto_wr_flag", o_wr_timeout, 64'(exp_wr));
        chk("rto_cnt", o_timeout_cnt, 64'(exp_cnt));
        chk("rto_err_addr", o_err_addr, 64'(ra));
        chk("rto_m_rready", m_bus.rready, 64'd1);
        tick();                       // upstream takes the error response
        ticks(late_gap);
        m_bus.rvalid = 1'b1;
        m_bus.rdata  = 64'h0000_0000_0000_BAD0;
        m_bus.rresp  = 2'b00;
        tick();
        m_bus.rvalid = 1'b0;
        chk("rto_late_rready", m_bus.rready, 64'd0);
        chk("rto_late_s_rvalid", s_bus.rvalid, 64'd0);
    endtask

    // Read and write issued together, both accepted, neither answered.
    task automatic both_timeout(input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                                input logic [CW-1:0] exp_cnt);
        m_bus.awready = 1'b1;
        m_bus.wready  = 1'b1;
        m_bus.arready = 1'b1;
        s_bus.awaddr  = wa;
        s_bus.awvalid = 1'b1;
        s_bus.wdata   = 64'h0000_0000_0000_5555;
        s_bus.wvalid  = 1'b1;
        s_bus.araddr  = ra;
        s_bus.arvalid = 1'b1;
        tick();
        s_bus.awvalid = 1'b0;
        s_bus.wvalid  = 1'b0;
        s_bus.arvalid = 1'b0;
        ticks(15);
        chk("both_early_bvalid", s_bus.bvalid, 64'd0);
        tick();
        chk("both_bvalid", s_bus.bvalid, 64'd1);
        chk("both_bresp", s_bus.bresp, 64'd2);
        chk("both_rvalid", s_bus.rvalid, 64'd1);
        chk("both_rresp", s_bus.rresp, 64'd2);
        chk("both_wr_flag", o_wr_timeout, 64'd1);
        chk("both_rd_flag", o_rd_timeout, 64'd1);
        chk("both_cnt", o_timeout_cnt, 64'(exp_cnt));
        chk("both_err_addr", o_err_addr, 64'(ra));
        tick();
        m_bus.bvalid = 1'b1;
        m_bus.bresp  = 2'b00;
        m_bus.rvalid = 1'b1;
        m_bus.rresp  = 2'b00;
        tick();
        m_bus.bvalid = 1'b0;
        m_bus.rvalid = 1'b0;
        chk("both_late_bready", m_bus.bready, 64'd0);
        chk("both_late_rready", m_bus.rready, 64'd0);
        chk("both_late_s_bvalid", s_bus.bvalid, 64'd0);
        chk("both_late_s_rvalid", s_bus.rvalid, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_stat = 1'b0;
        s_bus.awaddr = '0; s_bus.awprot = 3'b000; s_bus.awvalid = 1'b0;
        s_bus.wdata = '0; s_bus.wstrb = 8'hFF; s_bus.wvalid = 1'b0;
        s_bus.bready = 1'b0;
        s_bus.araddr = '0; s_bus.arprot = 3'b000; s_bus.arvalid = 1'b0;
        s_bus.rready = 1'b0;
        m_bus.awready = 1'b0; m_bus.wready = 1'b0;
        m_bus.bvalid = 1'b0; m_bus.bresp = 2'b00;
        m_bus.arready = 1'b0;
        m_bus.rvalid = 1'b0; m_bus.rdata = '0; m_bus.rresp = 2'b00;

        // ---- reset state ----
        ticks(2);
        chk("rst_s_awready", s_bus.awready, 64'd0);
        chk("rst_s_wready", s_bus.wready, 64'd0);
        chk("rst_s_arready", s_bus.arready, 64'd0);
        chk("rst_s_bvalid", s_bus.bvalid, 64'd0);
        chk("rst_s_rvalid", s_bus.rvalid, 64'd0);
        chk("rst_m_awvalid", m_bus.awvalid, 64'd0);
        chk("rst_m_wvalid", m_bus.wvalid, 64'd0);
        chk("rst_m_arvalid", m_bus.arvalid, 64'd0);
        chk("rst_m_bready", m_bus.bready, 64'd0);
        chk("rst_m_rready", m_bus.rready, 64'd0);
        chk("rst_status", {o_wr_timeout, o_rd_timeout, o_timeout_cnt, o_err_addr}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_awready", s_bus.awready, 64'd1);
        chk("idle_arready", s_bus.arready, 64'd1);

        // ---- normal write, B after 3 cycles ----
        s_bus.awaddr = 19'h00100; s_bus.awvalid = 1'b1;
        s_bus.wdata = 64'h0000_0000_DEAD_BEEF; s_bus.wvalid = 1'b1;
        s_bus.bready = 1'b1; s_bus.rready = 1'b1;
        tick();
        s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
        chk("wr_m_awvalid", m_bus.awvalid, 64'd1);
        chk("wr_m_awaddr", m_bus.awaddr, 64'h100);
        chk("wr_m_wvalid", m_bus.wvalid, 64'd1);
        chk("wr_m_wdata", m_bus.wdata, 64'h0000_0000_DEAD_BEEF);
        chk("wr_m_wstrb", m_bus.wstrb, 64'hFF);
        chk("wr_s_awready_busy", s_bus.awready, 64'd0);
        m_bus.awready = 1'b1; m_bus.wready = 1'b1;
        tick();
        m_bus.awready = 1'b0; m_bus.wready = 1'b0;
        chk("wr_m_awvalid_drop", m_bus.awvalid, 64'd0);
        chk("wr_m_bready", m_bus.bready, 64'd1);
        ticks(2);
        m_bus.bvalid = 1'b1; m_bus.bresp = 2'b00;
        chk("wr_s_bvalid_pre", s_bus.bvalid, 64'd0);
        tick();
        m_bus.bvalid = 1'b0;
        chk("wr_s_bvalid", s_bus.bvalid, 64'd1);
        chk("wr_s_bresp", s_bus.bresp, 64'd0);
        chk("wr_m_bready_drop", m_bus.bready, 64'd0);
        tick();
        chk("wr_s_bvalid_done", s_bus.bvalid, 64'd0);
        chk("wr_status", {o_wr_timeout, o_rd_timeout, o_timeout_cnt}, 64'd0);

        // ---- read timeout, late R around cycle 40, then normal read ----
        rd_timeout(19'h0ABC8, 1'b0, 2'd1, 1'b0, 22);
        s_bus.araddr = 19'h00200; s_bus.arvalid = 1'b1;
        tick();
        s_bus.arvalid = 1'b0;
        chk("rd2_m_arvalid", m_bus.arvalid, 64'd1);
        chk("rd2_m_araddr", m_bus.araddr, 64'h200);
        tick();
        chk("rd2_m_rready", m_bus.rready, 64'd1);
        m_bus.rvalid = 1'b1; m_bus.rdata = 64'h0123_4567_89AB_CDEF; m_bus.rresp = 2'b01;
        tick();
        m_bus.rvalid = 1'b0;
        chk("rd2_s_rvalid", s_bus.rvalid, 64'd1);
        chk("rd2_s_rdata", s_bus.rdata, 64'h0123_4567_89AB_CDEF);
        chk("rd2_s_rresp", s_bus.rresp, 64'd1);
        tick();
        chk("rd2_cnt", o_timeout_cnt, 64'd1);

        // ---- write timeout with AW still pending, then fail-fast ----
        m_bus.awready = 1'b0; m_bus.wready = 1'b1;
        s_bus.awaddr = 19'h00300; s_bus.awvalid = 1'b1;
        s_bus.wdata = 64'h0000_0000_0000_0003; s_bus.wvalid = 1'b1;
        tick();
        s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
        ticks(15);
        chk("wto_early_bvalid", s_bus.bvalid, 64'd0);
        tick();
        chk("wto_bvalid", s_bus.bvalid, 64'd1);
        chk("wto_bresp", s_bus.bresp, 64'd2);
        chk("wto_wr_flag", o_wr_timeout, 64'd1);
        chk("wto_cnt", o_timeout_cnt, 64'd2);
        chk("wto_err_addr", o_err_addr, 64'h300);
        chk("wto_m_awvalid_held", m_bus.awvalid, 64'd1);
        tick();
        m_bus.wready = 1'b0;
        s_bus.awaddr = 19'h00400; s_bus.awvalid = 1'b1;
        s_bus.wdata = 64'h0000_0000_0000_0004; s_bus.wvalid = 1'b1;
        tick();
        s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
        chk("ff_bvalid", s_bus.bvalid, 64'd1);
        chk("ff_bresp", s_bus.bresp, 64'd2);
        chk("ff_m_awaddr_stable", m_bus.awaddr, 64'h300);
        chk("ff_cnt_unchanged", o_timeout_cnt, 64'd2);
        tick();
        chk("ff_m_awvalid_held", m_bus.awvalid, 64'd1);
        m_bus.awready = 1'b1;
        tick();
        m_bus.awready = 1'b0;
        chk("ff_m_awvalid_drop", m_bus.awvalid, 64'd0);
        chk("ff_m_bready", m_bus.bready, 64'd1);
        m_bus.bvalid = 1'b1; m_bus.bresp = 2'b00;
        tick();
        m_bus.bvalid = 1'b0;
        chk("ff_late_bready", m_bus.bready, 64'd0);
        chk("ff_late_s_bvalid", s_bus.bvalid, 64'd0);

        // ---- clear alone ----
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_status", {o_wr_timeout, o_rd_timeout, o_timeout_cnt, o_err_addr}, 64'd0);

        // ---- boundary: B lands in the count-15 cycle ----
        m_bus.awready = 1'b1; m_bus.wready = 1'b1;
        s_bus.awaddr = 19'h00500; s_bus.awvalid = 1'b1;
        s_bus.wdata = 64'h0000_0000_0000_0005; s_bus.wvalid = 1'b1;
        tick();
        s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
        ticks(15);
        m_bus.bvalid = 1'b1; m_bus.bresp = 2'b01;
        chk("race_bvalid_pre", s_bus.bvalid, 64'd0);
        tick();
        m_bus.bvalid = 1'b0;
        chk("race_bvalid", s_bus.bvalid, 64'd1);
        chk("race_bresp", s_bus.bresp, 64'd1);
        chk("race_wr_flag", o_wr_timeout, 64'd0);
        chk("race_cnt", o_timeout_cnt, 64'd0);
        tick();

        // ---- simultaneous timeouts, saturation, clear vs timeout ----
        both_timeout(19'h00700, 19'h00600, 2'd2);
        both_timeout(19'h00710, 19'h00610, 2'd3);
        rd_timeout(19'h00620, 1'b0, 2'd3, 1'b1, 0);
        rd_timeout(19'h00630, 1'b1, 2'd1, 1'b0, 0);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr2_status", {o_wr_timeout, o_rd_timeout, o_timeout_cnt, o_err_addr}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axil_csr_timeout_guard.md
Name: axil_csr_timeout_guard

Overview:
- Sits directly downstream of the ST2MM RX/TX bridge AXI-lite master port (`axi_m_if`), between it and the CSR fabric.
- Forwards MMIO reads and writes unchanged.
- If the fabric does not respond within a bounded time, it returns an error response upstream. This guarantees every host MMIO read gets a completion, so a hung CSR slave cannot hang the host.
- Late responses are absorbed. Timeout statistics and the failing address are exported for debug CSRs.

Parameters:
- ADDR_W, 19: AXI-lite address width; must match the interface.
- DATA_W, 64: AXI-lite data width; must match the interface.
- TIMEOUT_CYCLES, 4096: cycles allowed from downstream issue to response; legal range 2..65535.
- CNT_W, 16: width of the saturating timeout counter.

Ports:
- clk  input  1  CSR clock; all logic is in this single domain.
- rst  input  1  synchronous, active-high reset.
- s_if  ofs_fim_axi_lite_if.slave  -  upstream side, driven by the ST2MM bridge.
- m_if  ofs_fim_axi_lite_if.master  -  downstream side, toward the CSR fabric.
- clr_stat  input  1  one-cycle pulse; clears the sticky flags, the counter and the captured address.
- o_wr_timeout  output  1  sticky: at least one write has timed out.
- o_rd_timeout  output  1  sticky: at least one read has timed out.
- o_timeout_cnt  output  CNT_W  total timeouts (reads + writes); saturates at all-ones.
- o_err_addr  output  ADDR_W  address of the most recent timed-out transaction.

Behaviour:
- Reset: all of the following are 0.
  - s_if awready, wready, arready, bvalid, rvalid.
  - m_if awvalid, wvalid, arvalid, bready, rready.
  - All status outputs.
  - Both FSMs go to IDLE, both stale flags clear.
- Reset mid-operation abandons any downstream transaction; the fabric is reset together with this block.
- Write and read paths are independent FSMs. Each allows one outstanding transaction.
- Write FSM states: W_IDLE, W_ISSUE, W_WAIT, W_RESP.
  - W_IDLE: s awready=1 until AW is captured and s wready=1 until W is captured. They may arrive in either order or the same cycle.
  - W_IDLE, both captured: if wr_stale=0 go to W_ISSUE; if wr_stale=1 go to W_RESP with bresp=2'b10 (fail-fast, not forwarded).
  - W_ISSUE: m awvalid and wvalid asserted with the captured addr/data/strb/prot. Each deasserts independently on its ready. Once both are accepted, go to W_WAIT with m bready=1.
  - Counter: wcnt clears on entry to W_ISSUE and increments every cycle in W_ISSUE/W_WAIT.
  - Normal completion: m bvalid&&bready captures bresp; go to W_RESP. s bvalid asserts the cycle after the downstream handshake (1-cycle added latency).
  - Timeout: wcnt==TIMEOUT_CYCLES-1 with no response this cycle forces W_RESP with bresp=2'b10.
    - Sets o_wr_timeout, increments o_timeout_cnt, loads o_err_addr=awaddr.
    - Sets wr_stale=1 if any of awvalid, wvalid or the response is still pending downstream.
  - While stale, downstream valids stay asserted until accepted (AXI-compliant; never withdrawn). bready=1. The late B is dropped and clears wr_stale.
  - W_RESP: hold s bvalid/bresp until s bready, then go to W_IDLE.
- Read FSM states: R_IDLE, R_ISSUE, R_WAIT, R_RESP. Same structure as the write FSM, with these differences:
  - A timeout or fail-fast returns rresp=2'b10 and rdata=all-ones.
  - A normal read returns the downstream rdata/rresp registered, at 1-cycle added latency.
- Simultaneous events:
  - Response arrives in the cycle the count reaches the limit: the real response wins, no timeout is recorded.
  - Read and write timeouts in the same cycle: o_timeout_cnt increments by 2, and o_err_addr takes the read address.
  - clr_stat in the same cycle as a timeout: the timeout wins (flags set, cnt=1 or 2).
- Counter saturates at 2^CNT_W-1 and does not wrap.
- The guard introduces no reordering; the response order per channel equals the request order.

Test Plan:
- Normal write: addr 0x00100, data 0xDEAD_BEEF, slave B after 3 cycles with OKAY -> s bresp=2'b00 one cycle after the m B handshake. Status unchanged.
- Read timeout (TIMEOUT_CYCLES=16): slave never asserts rvalid -> s rvalid in the 16th cycle after R_ISSUE entry, rdata=0xFFFF_FFFF_FFFF_FFFF, rresp=2'b10, o_rd_timeout=1, o_timeout_cnt=1, o_err_addr=read address.
- Late response: after the read timeout above, slave returns R at cycle 40 -> m rready=1 and nothing appears on s_if. The next read is forwarded normally.
- Fail-fast: while the write path is stale, issue a new write -> bresp=2'b10 within 2 cycles. m awvalid is never re-asserted for it; the original awvalid stays high until awready.
- Boundary race: slave bvalid lands exactly on count 15 (TIMEOUT_CYCLES=16) -> real bresp forwarded, o_wr_timeout remains 0.
- Stats: read and write timeouts in the same cycle -> cnt +2 and o_err_addr=read address. clr_stat alone zeros all status outputs. Forcing the counter to 0xFFFF and adding another timeout leaves it at 0xFFFF.
